branch_rs_unit: RTL and testbench
=================================

BRANCH_RS_UNIT -- requirements
Module: branch_rs_unit

Interface
REQ-001 Parameter DEPTH, default 4, number of reservation entries (2..16).
REQ-002 Parameter XLEN, default 32, operand/PC width.
REQ-003 Parameter TAG_W, default 4, ROB tag width; all-ones is TAG_INVALID, meaning operand ready.
REQ-004 Parameter CDB_N, default 2, number of parallel result-broadcast channels.
REQ-005 Clock and reset SHALL be: clk (input, 1, rising-edge clock); rst (input, 1, synchronous active-high reset).
REQ-006 Insert port SHALL be: in_valid (input, 1); in_ready (output, 1, entry free); in_target (input, TAG_W); in_op (input, 3); in_val1, in_val2 (input, XLEN); in_tag1, in_tag2 (input, TAG_W); in_pc, in_offset (input, XLEN).
REQ-007 Broadcast port SHALL be: cdb_valid (input, CDB_N); cdb_tag (input, CDB_N x TAG_W); cdb_val (input, CDB_N x XLEN).
REQ-008 flush (input, 1) SHALL mean discard all speculative entries.
REQ-009 Result port SHALL be: out_valid (output, 1); out_target (output, TAG_W); out_taken (output, 1); out_next_pc (output, XLEN), all registered.

Function
REQ-010 Insert SHALL occur at the rising edge where in_valid && in_ready, into the lowest-index free entry.
REQ-011 in_ready SHALL be high iff at least one entry is free in registered state; a same-cycle issue SHALL NOT raise it.
REQ-012 At every edge, each valid entry operand whose tag matches any cdb_valid channel SHALL capture cdb_val and set its tag to TAG_INVALID; when several channels match, the lowest channel SHALL win.
REQ-013 Broadcast capture SHALL also apply to the operands being inserted in that same cycle.
REQ-014 An entry SHALL be eligible when valid and both tags are TAG_INVALID in registered state.
REQ-015 Each cycle, the oldest eligible entry (insertion order, tracked by per-entry age counter) SHALL be issued and freed at the edge; at most one issue per cycle.
REQ-016 Latency: insert with ready operands at edge k SHALL give out_valid high in the cycle after edge k+1; wakeup at edge k SHALL give out_valid after edge k+1.
REQ-017 out_valid SHALL be a one-cycle pulse per issue and low when nothing issues; other out_* SHALL hold their last values when out_valid is low.
REQ-018 Ops 0..5 are BEQ, BNE, BLT (signed), BGE (signed >=), BLTU, BGEU (unsigned >=). out_taken SHALL be the compare result.
REQ-019 out_next_pc SHALL be in_pc+in_offset if taken, else in_pc+4, modulo 2^XLEN (wrap ignored).
REQ-020 Op 6 (JAL) SHALL give taken=1 and next_pc=pc+offset; op 7 follows REQ-026.
REQ-021 flush at edge k SHALL invalidate all entries, drop any same-cycle insert, and force out_valid low after edge k; flush dominates insert, wakeup and issue.
REQ-022 Insert with full state SHALL be impossible (in_ready low); in_valid while not ready SHALL be ignored.

Reset
REQ-023 On rst at a rising edge, all entries SHALL become invalid, age counters zero, out_valid=0, out_target=TAG_INVALID, out_taken=0, out_next_pc=0.
REQ-024 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-025 rst asserted mid-operation SHALL discard all pending entries with no issue in that cycle.

Configuration
REQ-026 With BRU_JALR_EN defined, op 7 (JALR) SHALL give taken=1 and next_pc=(val1+offset) with bit 0 cleared; without it, op 7 SHALL give taken=0 and next_pc=pc+4.

Structure
REQ-027 Package bru_pkg SHALL hold the op encoding enum, TAG_INVALID generator function and entry struct typedef.
REQ-028 The combinational condition/target logic SHALL be sub-module branch_cond_eval; storage, wakeup, age and select logic stay in branch_rs_unit.

Verification
REQ-029 BEQ with val1=5, val2=5, both ready, pc=0x100, off=0x20, target=3 -> out_valid one cycle after next edge, taken=1, next_pc=0x120, target=3.
REQ-030 BLT with -1 vs 1 -> taken=1; BLTU with 0xFFFFFFFF vs 1 -> taken=0, next_pc=pc+4.
REQ-031 Fill 4 entries waiting on tag 7, then cdb tag 7 val 9 -> issues over 4 consecutive cycles in insertion order; in_ready reasserts after the first issue.
REQ-032 Insert with tag1=2 in the same cycle as cdb tag 2 val 0x10 -> operand captured; issues without further broadcast.
REQ-033 flush with 3 pending entries plus a simultaneous insert -> no out_valid afterwards, in_ready=1, entries empty.
REQ-034 JALR val1=0x203, off=0 -> next_pc=0x202 with BRU_JALR_EN; taken=0, next_pc=pc+4 without it.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types for the branch reservation station: op encoding, entry
// control fields and the invalid-tag helper.
package bru_pkg;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLT  = 3'd2,
    OP_BGE  = 3'd3,
    OP_BLTU = 3'd4,
    OP_BGEU = 3'd5,
    OP_JAL  = 3'd6,
    OP_JALR = 3'd7
  } bru_op_e;

  // Wide enough for the relative age of up to 16 entries.
  localparam int unsigned AGE_W = 4;

  // Control portion of an entry; operand/PC payload lives in
  // width-parameterised arrays in the station itself.
  typedef struct packed {
    logic             valid;
    bru_op_e          op;
    logic [AGE_W-1:0] age;
  } rs_entry_t;

  // All-ones tag of the given width, used as the "operand ready" marker.
  function automatic logic [31:0] tag_invalid(input int unsigned tag_w);
    return (tag_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition and next-PC evaluation (combinational).
// Optional feature: define BRU_JALR_EN to resolve op 7 as JALR.
module branch_cond_eval
  import bru_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  bru_op_e         op,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  output logic            taken,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] tgt_pc;
`ifdef BRU_JALR_EN
  logic [XLEN-1:0] jalr_sum;
`endif

  assign seq_pc = pc + XLEN'(4);
  assign tgt_pc = pc + offset;
`ifdef BRU_JALR_EN
  assign jalr_sum = val1 + offset;
`endif

  // Compare per op, then choose the fall-through or branch target.
  always_comb begin
    taken   = 1'b0;
    next_pc = seq_pc;
    unique case (op)
      OP_BEQ:  taken = (val1 == val2);
      OP_BNE:  taken = (val1 != val2);
      OP_BLT:  taken = ($signed(val1) <  $signed(val2));
      OP_BGE:  taken = ($signed(val1) >= $signed(val2));
      OP_BLTU: taken = (val1 <  val2);
      OP_BGEU: taken = (val1 >= val2);
      OP_JAL:  taken = 1'b1;
      OP_JALR: taken = 1'b0;
      default: taken = 1'b0;
    endcase
    if (taken) next_pc = tgt_pc;
`ifdef BRU_JALR_EN
    if (op == OP_JALR) begin
      taken   = 1'b1;
      next_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/branch_rs_unit.sv
// Branch reservation station: stores waiting branches, captures operands
// from the result broadcast, issues the oldest ready entry each cycle and
// registers its resolved outcome.
// Optional feature: BRU_JALR_EN (JALR resolution in branch_cond_eval).
module branch_rs_unit
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CDB_N = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TAG_W-1:0]            in_target,
  input  logic [2:0]                  in_op,
  input  logic [XLEN-1:0]             in_val1,
  input  logic [XLEN-1:0]             in_val2,
  input  logic [TAG_W-1:0]            in_tag1,
  input  logic [TAG_W-1:0]            in_tag2,
  input  logic [XLEN-1:0]             in_pc,
  input  logic [XLEN-1:0]             in_offset,
  input  logic [CDB_N-1:0]            cdb_valid,
  input  logic [CDB_N-1:0][TAG_W-1:0] cdb_tag,
  input  logic [CDB_N-1:0][XLEN-1:0]  cdb_val,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [TAG_W-1:0]            out_target,
  output logic                        out_taken,
  output logic [XLEN-1:0]             out_next_pc
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] TAG_INV = TAG_W'(tag_invalid(TAG_W));

  rs_entry_t        entry_q  [DEPTH];
  rs_entry_t        entry_d  [DEPTH];
  logic [TAG_W-1:0] target_q [DEPTH];
  logic [TAG_W-1:0] target_d [DEPTH];
  logic [TAG_W-1:0] tag1_q   [DEPTH];
  logic [TAG_W-1:0] tag1_d   [DEPTH];
  logic [TAG_W-1:0] tag2_q   [DEPTH];
  logic [TAG_W-1:0] tag2_d   [DEPTH];
  logic [XLEN-1:0]  val1_q   [DEPTH];
  logic [XLEN-1:0]  val1_d   [DEPTH];
  logic [XLEN-1:0]  val2_q   [DEPTH];
  logic [XLEN-1:0]  val2_d   [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  pc_d     [DEPTH];
  logic [XLEN-1:0]  off_q    [DEPTH];
  logic [XLEN-1:0]  off_d    [DEPTH];

  logic             out_valid_q,   out_valid_d;
  logic [TAG_W-1:0] out_target_q,  out_target_d;
  logic             out_taken_q,   out_taken_d;
  logic [XLEN-1:0]  out_next_pc_q, out_next_pc_d;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [AGE_W-1:0] sel_age;
  logic             do_insert;
  logic             do_issue;
  logic             ev_taken;
  logic [XLEN-1:0]  ev_next_pc;

  // Lowest-index free slot; its existence is the ready indication.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!entry_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Oldest eligible entry: age counts younger valid entries, so the
  // largest age wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_q[i].valid && (tag1_q[i] == TAG_INV) && (tag2_q[i] == TAG_INV) &&
          (!sel_found || (entry_q[i].age > sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = entry_q[i].age;
      end
    end
  end

  assign in_ready  = free_found;
  assign do_insert = in_valid && free_found && !flush;
  assign do_issue  = sel_found && !flush;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .op      (entry_q[sel_idx].op),
    .val1    (val1_q[sel_idx]),
    .val2    (val2_q[sel_idx]),
    .pc      (pc_q[sel_idx]),
    .offset  (off_q[sel_idx]),
    .taken   (ev_taken),
    .next_pc (ev_next_pc)
  );

  // Next state: wakeup, age maintenance, issue/free, insert, then flush.
  always_comb begin
    logic             hit1;
    logic             hit2;
    logic [TAG_W-1:0] nt1;
    logic [TAG_W-1:0] nt2;
    logic [XLEN-1:0]  nv1;
    logic [XLEN-1:0]  nv2;
    hit1     = 1'b0;
    hit2     = 1'b0;
    entry_d  = entry_q;
    target_d = target_q;
    tag1_d   = tag1_q;
    tag2_d   = tag2_q;
    val1_d   = val1_q;
    val2_d   = val2_q;
    pc_d     = pc_q;
    off_d    = off_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_q[i].valid) begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned c = 0; c < CDB_N; c++) begin
          if (cdb_valid[c] && !hit1 && (tag1_q[i] != TAG_INV) && (cdb_tag[c] == tag1_q[i])) begin
            hit1      = 1'b1;
            val1_d[i] = cdb_val[c];
            tag1_d[i] = TAG_INV;
          end
          if (cdb_valid[c] && !hit2 && (tag2_q[i] != TAG_INV) && (cdb_tag[c] == tag2_q[i])) begin
            hit2      = 1'b1;
            val2_d[i] = cdb_val[c];
            tag2_d[i] = TAG_INV;
          end
        end
        if (do_issue && (IDX_W'(i) == sel_idx)) begin
          entry_d[i].valid = 1'b0;
          entry_d[i].age   = '0;
        end else begin
          // Every survivor gains the new entry as a younger peer and loses
          // the issued one if that one was younger than itself.
          entry_d[i].age = entry_q[i].age + AGE_W'(do_insert)
                         - AGE_W'(do_issue && (entry_q[i].age > sel_age));
        end
      end
    end

    nt1  = in_tag1;
    nt2  = in_tag2;
    nv1  = in_val1;
    nv2  = in_val2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned c = 0; c < CDB_N; c++) begin
      if (cdb_valid[c] && !hit1 && (in_tag1 != TAG_INV) && (cdb_tag[c] == in_tag1)) begin
        hit1 = 1'b1;
        nv1  = cdb_val[c];
        nt1  = TAG_INV;
      end
      if (cdb_valid[c] && !hit2 && (in_tag2 != TAG_INV) && (cdb_tag[c] == in_tag2)) begin
        hit2 = 1'b1;
        nv2  = cdb_val[c];
        nt2  = TAG_INV;
      end
    end
    if (do_insert) begin
      entry_d[free_idx].valid = 1'b1;
      entry_d[free_idx].op    = bru_op_e'(in_op);
      entry_d[free_idx].age   = '0;
      target_d[free_idx]      = in_target;
      tag1_d[free_idx]        = nt1;
      tag2_d[free_idx]        = nt2;
      val1_d[free_idx]        = nv1;
      val2_d[free_idx]        = nv2;
      pc_d[free_idx]          = in_pc;
      off_d[free_idx]         = in_offset;
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_d[i] = '0;
    end
  end

  // Result register: loads on issue, otherwise holds.
  always_comb begin
    out_valid_d   = do_issue;
    out_target_d  = out_target_q;
    out_taken_d   = out_taken_q;
    out_next_pc_d = out_next_pc_q;
    if (do_issue) begin
      out_target_d  = target_q[sel_idx];
      out_taken_d   = ev_taken;
      out_next_pc_d = ev_next_pc;
    end
  end

  // Control state and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      out_valid_q   <= 1'b0;
      out_target_q  <= TAG_INV;
      out_taken_q   <= 1'b0;
      out_next_pc_q <= '0;
    end else begin
      entry_q       <= entry_d;
      out_valid_q   <= out_valid_d;
      out_target_q  <= out_target_d;
      out_taken_q   <= out_taken_d;
      out_next_pc_q <= out_next_pc_d;
    end
  end

  // Entry payload; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    target_q <= target_d;
    tag1_q   <= tag1_d;
    tag2_q   <= tag2_d;
    val1_q   <= val1_d;
    val2_q   <= val2_d;
    pc_q     <= pc_d;
    off_q    <= off_d;
  end

  assign out_valid   = out_valid_q;
  assign out_target  = out_target_q;
  assign out_taken   = out_taken_q;
  assign out_next_pc = out_next_pc_q;

endmodule

// File: tb/tb_branch_rs_unit.sv
// Scoreboard bench for branch_rs_unit (default parameters).
module tb_branch_rs_unit;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_target;
  logic [2:0]       in_op;
  logic [31:0]      in_val1, in_val2, in_pc, in_offset;
  logic [3:0]       in_tag1, in_tag2;
  logic [1:0]       cdb_valid;
  logic [1:0][3:0]  cdb_tag;
  logic [1:0][31:0] cdb_val;
  logic             flush;
  logic             out_valid;
  logic [3:0]       out_target;
  logic             out_taken;
  logic [31:0]      out_next_pc;

  typedef struct {
    logic [3:0]  tgt;
    logic        taken;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulse_cnt = 0;
  int   p0;

  always #5 clk = ~clk;

  branch_rs_unit #(.DEPTH(4), .XLEN(32), .TAG_W(4), .CDB_N(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target), .in_op(in_op),
    .in_val1(in_val1), .in_val2(in_val2), .in_tag1(in_tag1), .in_tag2(in_tag2),
    .in_pc(in_pc), .in_offset(in_offset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .flush(flush),
    .out_valid(out_valid), .out_target(out_target), .out_taken(out_taken),
    .out_next_pc(out_next_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference branch resolution.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] v1, v2, pc, off,
                                 input logic [3:0] tgt);
    exp_t e;
    e.tgt   = tgt;
    e.taken = 1'b0;
    case (op)
      3'd0: e.taken = (v1 == v2);
      3'd1: e.taken = (v1 != v2);
      3'd2: e.taken = ($signed(v1) < $signed(v2));
      3'd3: e.taken = ($signed(v1) >= $signed(v2));
      3'd4: e.taken = (v1 < v2);
      3'd5: e.taken = (v1 >= v2);
      3'd6: e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    e.npc = e.taken ? pc + off : pc + 32'd4;
`ifdef BRU_JALR_EN
    if (op == 3'd7) begin
      e.taken = 1'b1;
      e.npc   = (v1 + off) & 32'hFFFF_FFFE;
    end
`endif
    return e;
  endfunction

  task automatic push_exp(input logic [2:0] op, input logic [31:0] v1, v2, pc, off,
                          input logic [3:0] tgt);
    exp_q.push_back(model(op, v1, v2, pc, off, tgt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one insert across one clock edge.
  task automatic ins(input logic [2:0] op, input logic [31:0] v1, v2,
                     input logic [3:0] t1, t2, input logic [31:0] pc, off,
                     input logic [3:0] tgt);
    in_valid = 1'b1; in_op = op; in_val1 = v1; in_val2 = v2;
    in_tag1 = t1; in_tag2 = t2; in_pc = pc; in_offset = off; in_target = tgt;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [3:0] tg0, input logic [31:0] v0,
                         input logic [3:0] tg1, input logic [31:0] v1);
    cdb_valid = v; cdb_tag[0] = tg0; cdb_val[0] = v0; cdb_tag[1] = tg1; cdb_val[1] = v1;
  endtask

  task automatic wait_ready();
    for (int w = 0; w < 20 && !in_ready; w++) tick();
    if (!in_ready) check("ready_timeout", 1'b0, 1'b1);
  endtask

  // Scoreboard: compare each issued result against the next expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("unexpected_issue", 1'b1, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        check("out_target",  out_target,  mon_e.tgt);
        check("out_taken",   out_taken,   mon_e.taken);
        check("out_next_pc", out_next_pc, mon_e.npc);
      end
    end
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] rv1, rv2, rpc, roff;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    in_op = '0; in_val1 = '0; in_val2 = '0; in_tag1 = '1; in_tag2 = '1;
    in_pc = '0; in_offset = '0; in_target = '0;
    set_cdb(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid",   out_valid,   1'b0);
    check("rst_out_target",  out_target,  4'hF);
    check("rst_out_taken",   out_taken,   1'b0);
    check("rst_out_next_pc", out_next_pc, 32'h0);
    check("rst_in_ready",    in_ready,    1'b1);

    // BEQ latency and pulse width
    push_exp(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 4'd3);
    ins(3'd0, 32'd5, 32'd5, 4'hF, 4'hF, 32'h100, 32'h20, 4'd3);
    check("lat_edge_k", out_valid, 1'b0);
    tick();
    check("lat_edge_k1", out_valid, 1'b1);
    tick();
    check("pulse_low", out_valid, 1'b0);

    // Signed vs unsigned compare, back to back
    push_exp(3'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 4'd4);
    ins(3'd2, 32'hFFFF_FFFF, 32'd1, 4'hF, 4'hF, 32'h200, 32'h40, 4'd4);
    push_exp(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 4'd5);
    ins(3'd4, 32'hFFFF_FFFF, 32'd1, 4'hF, 4'hF, 32'h200, 32'h40, 4'd5);
    repeat (3) tick();

    // Fill all entries waiting on tag 7, wake together
    push_exp(3'd0, 32'd9, 32'd9,  32'h1000, 32'h10, 4'd8);
    ins(3'd0, 32'h0, 32'd9,  4'd7, 4'hF, 32'h1000, 32'h10, 4'd8);
    push_exp(3'd1, 32'd9, 32'd9,  32'h1100, 32'h10, 4'd9);
    ins(3'd1, 32'h0, 32'd9,  4'd7, 4'hF, 32'h1100, 32'h10, 4'd9);
    push_exp(3'd3, 32'd9, 32'd3,  32'h1200, 32'h30, 4'd10);
    ins(3'd3, 32'h0, 32'd3,  4'd7, 4'hF, 32'h1200, 32'h30, 4'd10);
    check("ready_3of4", in_ready, 1'b1);
    push_exp(3'd4, 32'd9, 32'd10, 32'h1300, 32'h40, 4'd11);
    ins(3'd4, 32'h0, 32'd10, 4'd7, 4'hF, 32'h1300, 32'h40, 4'd11);
    check("ready_full", in_ready, 1'b0);
    in_valid = 1'b1; in_target = 4'd12; in_tag1 = 4'hF; in_tag2 = 4'hF;
    set_cdb(2'b01, 4'd7, 32'd9, 4'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    check("ready_after_wake", in_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("burst_valid", out_valid, 1'b1);
      if (k == 0) check("ready_after_issue", in_ready, 1'b1);
    end
    tick();
    check("burst_end", out_valid, 1'b0);

    // Age order independent of slot index
    push_exp(3'd6, 32'd0, 32'd0, 32'h2000, 32'h80, 4'd1);
    ins(3'd6, 32'd0, 32'd0, 4'hF, 4'hF, 32'h2000, 32'h80, 4'd1);
    push_exp(3'd0, 32'd4, 32'd4, 32'h2100, 32'h8, 4'd2);
    ins(3'd0, 32'd0, 32'd4, 4'd3, 4'hF, 32'h2100, 32'h8, 4'd2);
    push_exp(3'd1, 32'd4, 32'd4, 32'h2200, 32'h8, 4'd6);
    ins(3'd1, 32'd0, 32'd4, 4'd3, 4'hF, 32'h2200, 32'h8, 4'd6);
    set_cdb(2'b01, 4'd3, 32'd4, 4'd0, 32'd0);
    tick();
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    repeat (4) tick();

    // Same-cycle capture on insert
    push_exp(3'd0, 32'h10, 32'h10, 32'h400, 32'h8, 4'd13);
    set_cdb(2'b01, 4'd2, 32'h10, 4'd0, 32'd0);
    ins(3'd0, 32'hDEAD, 32'h10, 4'd2, 4'hF, 32'h400, 32'h8, 4'd13);
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
    check("capture_issue", out_valid, 1'b1);
    repeat (2) tick();

    // Lowest broadcast channel wins
    push_exp(3'd0, 32'd1, 32'd1, 32'h500, 32'h10, 4'd14);
    ins(3'd0, 32'd1, 32'h0, 4'hF, 4'd5, 32'h500, 32'h10, 4'd14);
    set_cdb(2'b11, 4'd5, 32'd1, 4'd5, 32'd2);
    tick();
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    repeat (3) tick();

    // JALR (resolution depends on BRU_JALR_EN)
    push_exp(3'd7, 32'h203, 32'h0, 32'h300, 32'h0, 4'd0);
    ins(3'd7, 32'h203, 32'h0, 4'hF, 4'hF, 32'h300, 32'h0, 4'd0);
    repeat (3) tick();

    // Flush with pending entries and a simultaneous insert
    ins(3'd0, 32'd0, 32'd0, 4'd7, 4'hF, 32'h600, 32'h4, 4'd1);
    ins(3'd0, 32'd0, 32'd0, 4'd7, 4'hF, 32'h604, 32'h4, 4'd2);
    ins(3'd0, 32'd0, 32'd0, 4'd7, 4'hF, 32'h608, 32'h4, 4'd6);
    p0 = pulse_cnt;
    flush = 1'b1;
    ins(3'd6, 32'd0, 32'd0, 4'hF, 4'hF, 32'h700, 32'h4, 4'd12);
    flush = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    set_cdb(2'b01, 4'd7, 32'd0, 4'd0, 32'd0);
    tick();
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    repeat (4) tick();
    check("flush_quiet", pulse_cnt - p0, 0);
    for (int k = 0; k < 3; k++) ins(3'd0, 32'd0, 32'd0, 4'd9, 4'hF, 32'h800, 32'h4, 4'd1);
    check("flush_empty_3", in_ready, 1'b1);
    ins(3'd0, 32'd0, 32'd0, 4'd9, 4'hF, 32'h800, 32'h4, 4'd1);
    check("flush_empty_4", in_ready, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_ready", in_ready, 1'b1);

    // Random ready-operand branches
    for (int k = 0; k < 24; k++) begin
      rop  = 3'($urandom_range(0, 7));
      rv1  = $urandom();
      rv2  = ($urandom_range(0, 3) == 0) ? rv1 : $urandom();
      rpc  = $urandom() & 32'hFFFF_FFFC;
      roff = $urandom() & 32'h0000_0FFC;
      wait_ready();
      push_exp(rop, rv1, rv2, rpc, roff, 4'(k % 15));
      ins(rop, rv1, rv2, 4'hF, 4'hF, rpc, roff, 4'(k % 15));
    end
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick();
    check("drain", exp_q.size(), 0);

    // Reset mid-operation discards pending entries
    ins(3'd6, 32'd0, 32'd0, 4'd6, 4'hF, 32'h900, 32'h4, 4'd1);
    ins(3'd6, 32'd0, 32'd0, 4'd6, 4'hF, 32'h904, 32'h4, 4'd2);
    p0 = pulse_cnt;
    rst = 1'b1;
    ins(3'd6, 32'd0, 32'd0, 4'hF, 4'hF, 32'h908, 32'h4, 4'd3);
    rst = 1'b0;
    check("rst2_out_valid", out_valid, 1'b0);
    check("rst2_out_target", out_target, 4'hF);
    check("rst2_in_ready", in_ready, 1'b1);
    set_cdb(2'b01, 4'd6, 32'd0, 4'd0, 32'd0);
    tick();
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    repeat (4) tick();
    check("rst2_quiet", pulse_cnt - p0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
